noc_link_buffer: RTL and testbench
==================================

Name: noc_link_buffer

Overview:
- Parametrised, elastic link stage between two adjacent routers of a rectangular MESH_X x MESH_Y mesh. Generalises the fixed, wire-only router-to-router connection.
- Carries one flit per transfer: dest_x, dest_y, s_delta_x, s_delta_y, data.
- Buffers up to DEPTH flits with valid/ready on both sides, so mesh tops can pipeline long links and absorb back-pressure.
- One instance per directed link. Edge links are not instantiated.

Parameters:
- MESH_X, 4, mesh width in routers; XW = max(1,$clog2(MESH_X)).
- MESH_Y, 4, mesh height in routers; YW = max(1,$clog2(MESH_Y)).
- DATA_WIDTH, 32, payload bits.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low, synchronous deassert by the system.
- in_valid  in  1  upstream flit valid.
- in_ready  out  1  buffer can accept a flit.
- in_dest_x  in  XW  destination X.
- in_dest_y  in  YW  destination Y.
- in_s_delta_x  in  XW+1  signed remaining X hops.
- in_s_delta_y  in  YW+1  signed remaining Y hops.
- in_data  in  DATA_WIDTH  payload.
- out_valid  out  1  head flit valid.
- out_ready  in  1  downstream accepts.
- out_dest_x, out_dest_y, out_s_delta_x, out_s_delta_y, out_data  out  same widths as inputs  head flit fields.
- level  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Push = in_valid && in_ready. Pop = out_valid && out_ready. Both are evaluated on the rising edge of clk.
- Storage:
  - Circular array of DEPTH entries.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is $clog2(DEPTH+1) bits.
- in_ready = rst && (count != DEPTH). It is 0 while rst is low. It is not affected by out_ready in the same cycle, so there is no combinational ready path through the block.
- out_valid = (count != 0).
- out_* fields = entry[rd_ptr]. When out_valid is 0, fields hold the last value and carry no meaning.
- Latency: a flit pushed at edge N appears on out_valid/out_* after edge N (1 cycle), assuming the FIFO was empty.
- Ordering: strict FIFO. All fields of one flit stay together; fields are never modified (no delta arithmetic in this block).
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full (count == DEPTH): in_ready = 0, so a push cannot coincide with full. A pop in that cycle makes in_ready 1 in the next cycle.
- Empty (count == 0): pop impossible. A push makes out_valid 1 after the edge.
- Holding rules:
  - Upstream must hold in_valid and fields stable until accepted.
  - The block holds out_* stable while out_valid && !out_ready.
- Reset (rst low, any time including mid-transfer):
  - Immediately: count = 0, wr_ptr = 0, rd_ptr = 0, out_valid = 0, in_ready = 0, level = 0.
  - All buffered flits are discarded. Storage contents are not reset.
- level = count, registered.

Optional Feature:
- Macro: NOC_LINK_STATS_EN.
- Defined: adds two outputs.
  - stall_cnt (32 bits): increments each cycle with out_valid && !out_ready; saturates at 32'hFFFF_FFFF.
  - max_level ($clog2(DEPTH+1) bits): high-water mark of count.
  - Both reset to 0 on rst low.
- Not defined: neither port exists and no extra logic is generated. Core behaviour is identical in both builds.

Test Plan:
- Reset then idle: rst low for 3 cycles, then high -> out_valid = 0, level = 0; in_ready 0 during reset, 1 on the first cycle after.
- Single flit: push dest=(2,1), delta=(+2,-1), data=32'hDEAD_BEEF with out_ready = 1 -> out_valid high exactly 1 cycle later with identical fields; level returns to 0.
- Fill/back-pressure: DEPTH = 4, out_ready = 0, push 6 flits data = 1..6 -> in_ready drops after the 4th accept; level = 4; flits 5 and 6 held. Then out_ready = 1 -> outputs 1..6 in order, no loss or duplication.
- Simultaneous push/pop at level 2 for 10 cycles -> level stays 2; output sequence equals input sequence delayed by 2 transfers.
- Reset mid-operation: level = 3, assert rst asynchronously between edges -> out_valid and level go to 0 without a clock edge. After release, the next pushed flit (data = 32'h5) is the first one output.
- With NOC_LINK_STATS_EN: hold out_ready = 0 with 1 flit buffered for 7 cycles -> stall_cnt = 7, max_level = 1. After filling to 4, max_level = 4 and stays 4 after draining.

Source files
------------

// File: rtl/noc_link_buffer.sv
// noc_link_buffer: elastic valid/ready link stage between two adjacent mesh
// routers. Buffers up to DEPTH flits in a circular array; strict FIFO order,
// flit fields pass through unmodified. in_ready does not depend on out_ready,
// so there is no combinational path across the link.
// Optional build macro NOC_LINK_STATS_EN adds stall_cnt and max_level outputs.
module noc_link_buffer #(
  parameter int MESH_X     = 4,
  parameter int MESH_Y     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int XW = (MESH_X > 2) ? $clog2(MESH_X) : 1,
  localparam int YW = (MESH_Y > 2) ? $clog2(MESH_Y) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XW-1:0]         in_dest_x,
  input  logic [YW-1:0]         in_dest_y,
  input  logic [XW:0]           in_s_delta_x,
  input  logic [YW:0]           in_s_delta_y,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XW-1:0]         out_dest_x,
  output logic [YW-1:0]         out_dest_y,
  output logic [XW:0]           out_s_delta_x,
  output logic [YW:0]           out_s_delta_y,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         level
`ifdef NOC_LINK_STATS_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [CW-1:0]         max_level
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = XW + YW + (XW + 1) + (YW + 1) + DATA_WIDTH;

  logic [FW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  assign in_ready  = rst && (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = count;

  assign {out_dest_x, out_dest_y, out_s_delta_x, out_s_delta_y, out_data} = mem[rd_ptr];

  // Next occupancy from the push/pop pair of this cycle.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers and occupancy; reset discards all buffered flits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

  // Flit storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_dest_x, in_dest_y, in_s_delta_x, in_s_delta_y, in_data};
  end

`ifdef NOC_LINK_STATS_EN
  // Saturating count of cycles where the head flit is blocked downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end

  // High-water mark tracked on the post-edge occupancy so it moves with level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      max_level <= '0;
    else if (count_nxt > max_level)
      max_level <= count_nxt;
  end
`endif

endmodule

// File: tb/tb_noc_link_buffer.sv
// Testbench for noc_link_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_noc_link_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int XW    = 2;
  localparam int YW    = 2;
  localparam int CW    = 3;
  localparam int FW    = XW + YW + (XW + 1) + (YW + 1) + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] in_dest_x = '0;
  logic [YW-1:0] in_dest_y = '0;
  logic [XW:0]   in_s_delta_x = '0;
  logic [YW:0]   in_s_delta_y = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [XW-1:0] out_dest_x;
  logic [YW-1:0] out_dest_y;
  logic [XW:0]   out_s_delta_x;
  logic [YW:0]   out_s_delta_y;
  logic [DW-1:0] out_data;
  logic [CW-1:0] level;
`ifdef NOC_LINK_STATS_EN
  logic [31:0]   stall_cnt;
  logic [CW-1:0] max_level;
`endif

  logic [FW-1:0] in_flit;
  logic [FW-1:0] out_flit;
  assign in_flit  = {in_dest_x, in_dest_y, in_s_delta_x, in_s_delta_y, in_data};
  assign out_flit = {out_dest_x, out_dest_y, out_s_delta_x, out_s_delta_y, out_data};

  always #5 clk = ~clk;

  noc_link_buffer #(.MESH_X(4), .MESH_Y(4), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dest_x(in_dest_x), .in_dest_y(in_dest_y),
    .in_s_delta_x(in_s_delta_x), .in_s_delta_y(in_s_delta_y), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dest_x(out_dest_x), .out_dest_y(out_dest_y),
    .out_s_delta_x(out_s_delta_x), .out_s_delta_y(out_s_delta_y), .out_data(out_data),
    .level(level)
`ifdef NOC_LINK_STATS_EN
    , .stall_cnt(stall_cnt), .max_level(max_level)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of whole flits plus statistics.
  logic [FW-1:0] mq[$];
  bit            last_push = 1'b0;
  int unsigned   m_stall = 0;
  int            m_max = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      last_push = 1'b0;
      m_stall   = 0;
      m_max     = 0;
    end else begin
      bit pu, po;
      pu = in_valid && (mq.size() != DEPTH);
      po = (mq.size() != 0) && out_ready;
      if ((mq.size() != 0) && !out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall++;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(in_flit);
      last_push = pu;
      if (mq.size() > m_max) m_max = mq.size();
    end
  end

  // Per-cycle comparison against the model; also records flits handed downstream.
  logic [FW-1:0] dut_popped[$];
  always @(negedge clk) begin
    check("out_valid", out_valid, mq.size() != 0);
    check("in_ready", in_ready, rst && (mq.size() != DEPTH));
    check("level", level, mq.size());
    if (mq.size() != 0) check("head_flit", out_flit, mq[0]);
`ifdef NOC_LINK_STATS_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("max_level", max_level, m_max);
`endif
    if (out_valid && out_ready) dut_popped.push_back(out_flit);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [FW-1:0] f);
    {in_dest_x, in_dest_y, in_s_delta_x, in_s_delta_y, in_data} = f;
  endtask

  task automatic push_flit(input logic [FW-1:0] f);
    bit done;
    done = 1'b0;
    drive(f);
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (last_push) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("push_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  function automatic logic [FW-1:0] fl(input logic [31:0] d);
    logic [9:0] r;
    r = 10'($urandom);
    return {r, d};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] f5;
    logic [63:0]   r64;

    // Reset then idle
    repeat (3) cyc();
    check("rst_in_ready", in_ready, 64'd0);
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_level", level, 64'd0);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 64'd1);

    // Single flit: dest (2,1), delta (+2,-1)
    out_ready = 1'b1;
    push_flit({2'd2, 2'd1, 3'b010, 3'b111, 32'hDEAD_BEEF});
    check("single_valid", out_valid, 64'd1);
    check("single_data", out_data, 64'hDEAD_BEEF);
    check("single_dx", out_dest_x, 64'd2);
    check("single_dy", out_dest_y, 64'd1);
    check("single_sdx", out_s_delta_x, 64'h2);
    check("single_sdy", out_s_delta_y, 64'h7);
    cyc();
    check("single_drained_level", level, 64'd0);
    check("single_drained_valid", out_valid, 64'd0);

    // Fill and back-pressure
    out_ready = 1'b0;
    dut_popped.delete();
    for (int d = 1; d <= 4; d++) push_flit(fl(32'(d)));
    check("full_level", level, 64'd4);
    check("full_in_ready", in_ready, 64'd0);
    f5 = fl(32'd5);
    drive(f5);
    in_valid = 1'b1;
    repeat (3) cyc();
    check("full_hold_level", level, 64'd4);
    check("full_hold_ready", in_ready, 64'd0);
    out_ready = 1'b1;
    push_flit(f5);
    push_flit(fl(32'd6));
    repeat (8) cyc();
    check("fill_count", dut_popped.size(), 64'd6);
    for (int i = 0; i < 6 && i < dut_popped.size(); i++)
      check("fill_order", dut_popped[i][31:0], 64'(i + 1));

    // Simultaneous push/pop at level 2
    out_ready = 1'b0;
    dut_popped.delete();
    push_flit(fl(32'h100));
    push_flit(fl(32'h101));
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(fl(32'h102 + 32'(k)));
      in_valid = 1'b1;
      cyc();
      check("pp_level", level, 64'd2);
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    check("pp_count", dut_popped.size(), 64'd12);
    for (int i = 0; i < 12 && i < dut_popped.size(); i++)
      check("pp_order", dut_popped[i][31:0], 64'(32'h100 + 32'(i)));

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int d = 0; d < 3; d++) push_flit(fl(32'h20 + 32'(d)));
    check("mid_level", level, 64'd3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_valid", out_valid, 64'd0);
    check("async_level", level, 64'd0);
    check("async_ready", in_ready, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    out_ready = 1'b1;
    dut_popped.delete();
    push_flit(fl(32'h5));
    repeat (3) cyc();
    check("after_rst_count", dut_popped.size(), 64'd1);
    if (dut_popped.size() != 0) check("after_rst_first", dut_popped[0][31:0], 64'h5);

`ifdef NOC_LINK_STATS_EN
    // Statistics outputs
    @(negedge clk);
    #2;
    rst = 1'b0;
    #4;
    rst = 1'b1;
    out_ready = 1'b0;
    push_flit(fl(32'h77));
    repeat (7) cyc();
    check("stats_stall7", stall_cnt, 64'd7);
    check("stats_max1", max_level, 64'd1);
    for (int d = 0; d < 3; d++) push_flit(fl(32'h80 + 32'(d)));
    check("stats_max4", max_level, 64'd4);
    out_ready = 1'b1;
    repeat (6) cyc();
    check("stats_drained", level, 64'd0);
    check("stats_max_kept", max_level, 64'd4);
`endif

    // Random traffic honouring the upstream hold rule
    in_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || last_push) begin
        in_valid = ($urandom_range(0, 99) < 60);
        r64 = {$urandom(), $urandom()};
        drive(r64[FW-1:0]);
      end
      out_ready = ($urandom_range(0, 99) < (((c % 700) < 350) ? 80 : 25));
      cyc();
      if (c == 1500) begin
        #2;
        rst = 1'b0;
        #6;
        rst = 1'b1;
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) cyc();
    check("final_level", level, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
